// File: rtl/hdmi_packet_assembler_if.sv
// Packet-side signal bundle of hdmi_packet_assembler: header/subpacket payload in,
// 9-bit TERC4 feed with cycle index and end-of-packet pulse out.
interface hdmi_packet_assembler_if;
  logic        data_island_period;
  logic [23:0] header;
  logic [55:0] sub [3:0];
  logic [8:0]  packet_data;
  logic [4:0]  counter;
  logic        packet_done;

  modport master (
    output data_island_period, header, sub,
    input  packet_data, counter, packet_done
  );

  modport slave (
    input  data_island_period, header, sub,
    output packet_data, counter, packet_done
  );
endinterface

// File: rtl/hdmi_packet_assembler.sv
// HDMI data-island packet serialiser: BCH(32,24) header and BCH(64,56) subpacket parity, 9 bits/cycle over 32 cycles.
// Define HDMI_PACKET_ASSEMBLER_SHADOW_EN to capture header/sub at cycle 0 so the source may change afterwards.
module hdmi_packet_assembler (
  input  logic                   clk_pixel,
  input  logic                   reset,
  hdmi_packet_assembler_if.slave pkt
);
  localparam logic [7:0] BCH_POLY = 8'h83;

  function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic b);
    logic fb;
    fb = ecc[0] ^ b;
    return (ecc >> 1) ^ (fb ? BCH_POLY : 8'h00);
  endfunction

  logic [4:0]  idx_q, idx_d;
  logic [4:0]  counter_q, counter_d;
  logic [8:0]  pd_q, pd_d;
  logic        done_q, done_d;
  logic [7:0]  hdr_ecc_q, hdr_ecc_d;
  logic [7:0]  sub_ecc_q [3:0];
  logic [7:0]  sub_ecc_d [3:0];

  logic [23:0] hdr_src;
  logic [55:0] sub_src [3:0];
  logic [31:0] hdr_stream;
  logic [63:0] sub_stream [3:0];
  logic [3:0]  ch1, ch2;
  logic [7:0]  sub_half;

`ifdef HDMI_PACKET_ASSEMBLER_SHADOW_EN
  logic [23:0] shadow_hdr_q;
  logic [55:0] shadow_sub_q [3:0];

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      shadow_hdr_q <= '0;
      for (int n = 0; n < 4; n++) shadow_sub_q[n] <= '0;
    end else if (pkt.data_island_period && idx_q == 5'd0) begin
      shadow_hdr_q <= pkt.header;
      for (int n = 0; n < 4; n++) shadow_sub_q[n] <= pkt.sub[n];
    end
  end

  // Cycle 0 has not been captured yet, so it still reads the live inputs.
  always_comb begin
    hdr_src = (idx_q == 5'd0) ? pkt.header : shadow_hdr_q;
    for (int n = 0; n < 4; n++) sub_src[n] = (idx_q == 5'd0) ? pkt.sub[n] : shadow_sub_q[n];
  end
`else
  always_comb begin
    hdr_src = pkt.header;
    for (int n = 0; n < 4; n++) sub_src[n] = pkt.sub[n];
  end
`endif

  // Parity sits directly above the payload so one index walks data then ECC.
  always_comb begin
    hdr_stream = {hdr_ecc_q, hdr_src};
    ch1        = '0;
    ch2        = '0;
    sub_half   = '0;
    idx_d      = '0;
    counter_d  = counter_q;
    pd_d       = '0;
    done_d     = 1'b0;
    hdr_ecc_d  = '0;
    for (int n = 0; n < 4; n++) begin
      sub_ecc_d[n]  = '0;
      sub_stream[n] = {sub_ecc_q[n], sub_src[n]};
    end

    if (pkt.data_island_period) begin
      idx_d     = idx_q + 5'd1;
      counter_d = idx_q;
      done_d    = (idx_q == 5'd31);

      if (idx_q < 5'd24)
        hdr_ecc_d = ecc_step(hdr_ecc_q, hdr_stream[idx_q]);
      else if (idx_q != 5'd31)
        hdr_ecc_d = hdr_ecc_q;

      for (int n = 0; n < 4; n++) begin
        ch1[n] = sub_stream[n][{idx_q, 1'b0}];
        ch2[n] = sub_stream[n][{idx_q, 1'b1}];
        if (idx_q < 5'd28) begin
          sub_half     = ecc_step(sub_ecc_q[n], ch1[n]);
          sub_ecc_d[n] = ecc_step(sub_half, ch2[n]);
        end else if (idx_q != 5'd31) begin
          sub_ecc_d[n] = sub_ecc_q[n];
        end
      end

      pd_d = {ch2, ch1, hdr_stream[idx_q]};
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      counter_q <= '0;
      pd_q      <= '0;
      done_q    <= 1'b0;
      hdr_ecc_q <= '0;
      for (int n = 0; n < 4; n++) sub_ecc_q[n] <= '0;
    end else begin
      idx_q     <= idx_d;
      counter_q <= counter_d;
      pd_q      <= pd_d;
      done_q    <= done_d;
      hdr_ecc_q <= hdr_ecc_d;
      for (int n = 0; n < 4; n++) sub_ecc_q[n] <= sub_ecc_d[n];
    end
  end

  assign pkt.packet_data = pd_q;
  assign pkt.counter     = counter_q;
  assign pkt.packet_done = done_q;
endmodule

// File: tb/tb_hdmi_packet_assembler.sv
// Scoreboard bench for hdmi_packet_assembler: stimulus queues expected cycles, a negedge monitor compares.
// Honours HDMI_PACKET_ASSEMBLER_SHADOW_EN for the mid-packet header change case.
module tb_hdmi_packet_assembler;
  logic clk_pixel;
  logic reset;

  hdmi_packet_assembler_if ifc ();

  hdmi_packet_assembler dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .pkt       (ifc.slave)
  );

  typedef struct packed {
    logic [8:0] pd;
    logic [4:0] cnt;
    logic       done;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  exp_pd [32];
  logic [55:0] m_sub [4];
  int          n_chk;
  int          n_fail;
  logic        out_valid;

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
    return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
  endfunction

  // Bit-serial reference; header switches from h0 to h1 at cycle chg (chg<0: never).
  task automatic model(input logic [23:0] h0, input logic [23:0] h1, input int chg);
    logic [7:0]  he;
    logic [7:0]  se [4];
    logic [23:0] h;
    logic        c0;
    logic [3:0]  c1, c2;
    int          j, b;
    he = '0;
    for (int n = 0; n < 4; n++) se[n] = '0;
    for (int k = 0; k < 32; k++) begin
      h = (chg >= 0 && k >= chg) ? h1 : h0;
      if (k < 24) begin
        c0 = h[k[4:0]];
        he = ecc_step(he, c0);
      end else begin
        j  = k - 24;
        c0 = he[j[2:0]];
      end
      for (int n = 0; n < 4; n++) begin
        if (k < 28) begin
          b     = 2 * k;
          c1[n] = m_sub[n][b[5:0]];
          c2[n] = m_sub[n][b[5:0] + 6'd1];
          se[n] = ecc_step(ecc_step(se[n], c1[n]), c2[n]);
        end else begin
          j     = 2 * (k - 28);
          c1[n] = se[n][j[2:0]];
          c2[n] = se[n][j[2:0] + 3'd1];
        end
      end
      exp_pd[k] = {c2, c1, c0};
    end
  endtask

  task automatic set_sub();
    for (int n = 0; n < 4; n++) ifc.sub[n] = m_sub[n];
  endtask

  task automatic send(input int ncyc, input int chg, input logic [23:0] hnew);
    ifc.data_island_period = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == chg) ifc.header = hnew;
      exp_q.push_back('{pd: exp_pd[c], cnt: 5'(c), done: (c == 31)});
      @(posedge clk_pixel);
      #1;
    end
  endtask

  task automatic idle(input string name);
    ifc.data_island_period = 1'b0;
    @(posedge clk_pixel);
    #1;
    chk({name, "_idle_pd"}, 32'(ifc.packet_data), 32'd0);
    chk({name, "_idle_done"}, 32'(ifc.packet_done), 32'd0);
  endtask

  always @(posedge clk_pixel or posedge reset) begin
    if (reset) out_valid <= 1'b0;
    else       out_valid <= ifc.data_island_period;
  end

  always @(negedge clk_pixel) begin
    exp_t e;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("packet_data[c%0d]", e.cnt), 32'(ifc.packet_data), 32'(e.pd));
        chk($sformatf("counter[c%0d]", e.cnt), 32'(ifc.counter), 32'(e.cnt));
        chk($sformatf("packet_done[c%0d]", e.cnt), 32'(ifc.packet_done), 32'(e.done));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  ecc_h1;
    logic [23:0] h_a, h_b;
    int          waits;
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    ifc.data_island_period = 1'b0;
    ifc.header = '0;
    for (int n = 0; n < 4; n++) m_sub[n] = '0;
    set_sub();

    #3;
    chk("reset_pd", 32'(ifc.packet_data), 32'd0);
    chk("reset_counter", 32'(ifc.counter), 32'd0);
    chk("reset_done", 32'(ifc.packet_done), 32'd0);
    repeat (2) @(posedge clk_pixel);
    #1;
    reset = 1'b0;

    // All-zero packet: every cycle carries 0.
    for (int k = 0; k < 32; k++) exp_pd[k] = 9'd0;
    send(32, -1, '0);
    idle("zero");

    // header=1: hand-derived header parity 8'h4A, sent LSB first on cycles 24..31.
    ecc_h1 = 8'h4A;
    ifc.header = 24'h000001;
    for (int k = 0; k < 32; k++) begin
      if (k == 0)      exp_pd[k] = 9'd1;
      else if (k < 24) exp_pd[k] = 9'd0;
      else             exp_pd[k] = {8'd0, ecc_h1[k - 24]};
    end
    send(32, -1, '0);
    idle("hdr1");

    // ACR-style payload, identical in all four subpackets.
    for (int n = 0; n < 4; n++) m_sub[n] = 56'h00_0000_0000_1800;
    set_sub();
    ifc.header = 24'h000001;
    model(24'h000001, 24'h000001, -1);
    send(32, -1, '0);
    idle("acr");

    // Back-to-back packets with distinct headers and payloads.
    h_a = 24'hA5_3C_82;
    h_b = 24'h5A_C3_19;
    m_sub[0] = 56'h01_2345_6789_ABCD;
    m_sub[1] = 56'hFE_DCBA_9876_5432;
    m_sub[2] = 56'h80_0000_0000_0001;
    m_sub[3] = 56'h00_FF00_FF00_FF00;
    set_sub();
    ifc.header = h_a;
    model(h_a, h_a, -1);
    send(32, -1, '0);
    ifc.header = h_b;
    model(h_b, h_b, -1);
    send(32, -1, '0);
    idle("b2b");

    // Abort after 10 cycles, then a full packet restarting at cycle 0.
    ifc.header = h_a;
    model(h_a, h_a, -1);
    send(10, -1, '0);
    idle("abort");
    send(32, -1, '0);
    idle("after_abort");

    // Header change landing on cycle 6.
    ifc.header = h_a;
`ifdef HDMI_PACKET_ASSEMBLER_SHADOW_EN
    model(h_a, h_a, -1);
`else
    model(h_a, h_b, 6);
`endif
    send(32, 6, h_b);
    idle("midchange");

    // Asynchronous reset with idx at 17.
    ifc.header = h_b;
    model(h_b, h_b, -1);
    send(17, -1, '0);
    @(negedge clk_pixel);
    #1;
    reset = 1'b1;
    ifc.data_island_period = 1'b0;
    #1;
    chk("midreset_pd", 32'(ifc.packet_data), 32'd0);
    chk("midreset_counter", 32'(ifc.counter), 32'd0);
    chk("midreset_done", 32'(ifc.packet_done), 32'd0);
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    send(32, -1, '0);
    idle("after_reset");

    waits = 0;
    while (exp_q.size() != 0 && waits < 10) begin
      @(negedge clk_pixel);
      waits++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
